// File: rtl/updown_count_ctrl.sv
// Command sequencer for the 4-bit up/down counter: handshake accept, direction settle window,
// N single-cycle count enables, completion pulse, and a registered shadow count with wrap flag.
module updown_count_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [3:0] cmd_steps,
    input  logic       abort,
    output logic       up_down,
    output logic       cnt_en,
    output logic [3:0] q,
    output logic       busy,
    output logic       done,
    output logic       wrap
);

    typedef enum logic [1:0] {StIdle, StSettle, StRun, StDone} state_t;

    localparam logic [3:0] SettleLoad = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t     state;
    state_t     state_d;
    logic [3:0] settle_cnt;
    logic [3:0] remaining;

    always_comb begin
        state_d = state;
        case (state)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_steps == 4'd0) begin
                        state_d = StDone;
                    end else if (SETTLE > 0) begin
                        state_d = StSettle;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StDone;
                end else if (settle_cnt == 4'd0) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // The count on this edge is applied regardless of abort.
                if (abort || remaining == 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so none depend combinationally on inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            settle_cnt <= 4'd0;
            remaining  <= 4'd0;
            q          <= 4'd0;
            up_down    <= 1'b1;
            wrap       <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            cnt_en     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state     <= state_d;
            cmd_ready <= (state_d == StIdle);
            busy      <= (state_d != StIdle);
            cnt_en    <= (state_d == StRun);
            done      <= (state_d == StDone);
            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        up_down    <= cmd_dir;
                        remaining  <= cmd_steps;
                        wrap       <= 1'b0;
                        settle_cnt <= SettleLoad;
                    end
                end
                StSettle: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                StRun: begin
                    q         <= up_down ? q + 4'd1 : q - 4'd1;
                    remaining <= remaining - 4'd1;
                    if ((up_down && q == 4'd15) || (!up_down && q == 4'd0)) begin
                        wrap <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Bench for updown_count_ctrl: directed and random commands checked every cycle against a
// timeline model (cycles since accept, counts applied), plus literal checkpoints.
module tb_updown_count_ctrl;

    localparam int unsigned SETTLE = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_dir = 1'b0;
    logic [3:0] cmd_steps = 4'd0;
    logic       abort = 1'b0;
    logic       up_down;
    logic       cnt_en;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       wrap;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    updown_count_ctrl #(.SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .up_down   (up_down),
        .cnt_en    (cnt_en),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a command is described by its start value, direction, counts applied so far,
    // the cycle index k since accept, and the index at which the done cycle falls.
    bit m_act;
    int m_qs, m_cnt, m_k, m_dk;
    bit m_dir;

    function automatic int model_q();
        if (m_dir) return (m_qs + m_cnt) % 16;
        return ((m_qs - m_cnt) % 16 + 16) % 16;
    endfunction

    function automatic bit model_wrap();
        if (m_dir) return (m_qs + m_cnt) > 15;
        return m_cnt > m_qs;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act = 1'b0; m_qs = 0; m_cnt = 0; m_dir = 1'b1; m_k = 0; m_dk = 0;
        end else if (!m_act) begin
            if (cmd_valid) begin
                m_qs  = model_q();
                m_cnt = 0;
                m_dir = cmd_dir;
                m_k   = 1;
                m_dk  = (cmd_steps == 0) ? 1 : int'(SETTLE) + int'(cmd_steps) + 1;
                m_act = 1'b1;
            end
        end else if (m_k == m_dk) begin
            m_act = 1'b0;
        end else begin
            if (m_k > int'(SETTLE)) m_cnt++;
            if (abort) m_dk = m_k + 1;
            m_k++;
        end
    end

    always @(negedge clk) begin
        if (rst && chk_on) begin
            automatic bit e_done = m_act && (m_k == m_dk);
            automatic bit e_run  = m_act && (m_k < m_dk) && (m_k > int'(SETTLE));
            chk("cmd_ready", int'(cmd_ready), int'(!m_act));
            chk("busy", int'(busy), int'(m_act));
            chk("cnt_en", int'(cnt_en), int'(e_run));
            chk("done", int'(done), int'(e_done));
            chk("up_down", int'(up_down), int'(m_dir));
            chk("q", int'(q), model_q());
            chk("wrap", int'(wrap), int'(model_wrap()));
        end
    end

    // Issue one command from a negedge; return at the negedge after the done cycle.
    task automatic send(input logic dir, input logic [3:0] steps, input int abort_at,
                        input bit rnd_ab, output int seen);
        int g;
        seen = 0;
        cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = steps;
        g = 0;
        while (!cmd_ready && g < 100) begin
            @(negedge clk); g++;
        end
        if (!cmd_ready) chk("accept_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        g = 0;
        while (!done && g < 200) begin
            if (cnt_en) seen++;
            if (abort_at != 0 && cnt_en && seen == abort_at) abort = 1'b1;
            else if (rnd_ab) abort = ($urandom_range(0, 7) == 0);
            else abort = 1'b0;
            @(negedge clk); g++;
        end
        if (!done) chk("done_timeout", 0, 1);
        abort = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        chk("rst_q", int'(q), 0);
        chk("rst_up_down", int'(up_down), 1);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        chk_on = 1'b1;

        send(1'b1, 4'd3, 0, 1'b0, seen);
        chk("up3_en_cycles", seen, 3);
        chk("up3_q", int'(q), 3);
        chk("up3_wrap", int'(wrap), 0);

        send(1'b0, 4'd2, 0, 1'b0, seen);
        chk("down2_q", int'(q), 1);
        send(1'b0, 4'd3, 0, 1'b0, seen);
        chk("downwrap_q", int'(q), 14);
        chk("downwrap_wrap", int'(wrap), 1);
        send(1'b1, 4'd1, 0, 1'b0, seen);
        chk("wrap_cleared_q", int'(q), 15);
        chk("wrap_cleared", int'(wrap), 0);
        send(1'b1, 4'd6, 0, 1'b0, seen);
        chk("up6_q", int'(q), 5);

        send(1'b1, 4'd10, 4, 1'b0, seen);
        chk("abort_en_cycles", seen, 4);
        chk("abort_q", int'(q), 9);

        // Zero steps with cmd_valid held through busy.
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 4'd0;
        @(negedge clk);
        chk("zero_done", int'(done), 1);
        chk("zero_up_down", int'(up_down), 0);
        chk("zero_no_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("zero_ready", int'(cmd_ready), 1);
        @(negedge clk);
        chk("zero_reaccept", int'(done), 1);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);

        send(1'b1, 4'd7, 0, 1'b0, seen);
        chk("to_zero_q", int'(q), 0);
        send(1'b1, 4'd15, 0, 1'b0, seen);
        chk("full_en_cycles", seen, 15);
        chk("full_q", int'(q), 15);
        chk("full_wrap", int'(wrap), 0);
        send(1'b1, 4'd1, 0, 1'b0, seen);
        chk("full_wrap_q", int'(q), 0);
        chk("full_wrap_set", int'(wrap), 1);

        // Asynchronous reset in the middle of a run.
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 4'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_q", int'(q), 0);
        chk("midrst_cnt_en", int'(cnt_en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_up_down", int'(up_down), 1);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", int'(done), 0);
        end
        rst = 1'b1;
        send(1'b1, 4'd2, 0, 1'b0, seen);
        chk("postrst_q", int'(q), 2);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0, 1'b1, seen);
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/updown_count_ctrl.md
# updown_count_ctrl

Command-driven sequencer for the 4-bit up/down counter datapath. It accepts a count command (direction and step count) through a valid/ready handshake and holds the direction line steady for a settle window. It then issues exactly the requested number of single-cycle count enables and signals completion. It keeps a registered shadow of the count value with wrap detection, so downstream logic never samples the ripple chain directly.

## Interface
- SETTLE, 1: cycles `up_down` is held stable before the first enable (legal 0..15).
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept; high only in IDLE.
- cmd_dir  input  1  1 = count up, 0 = count down; sampled on accept.
- cmd_steps  input  4  number of counts, 0..15; sampled on accept.
- abort  input  1  terminate the active command.
- up_down  output  1  direction to counter datapath (registered).
- cnt_en  output  1  count enable, one pulse per step (registered).
- q  output  4  shadow count value.
- busy  output  1  high in SETTLE, RUN and DONE.
- done  output  1  one-cycle completion pulse.
- wrap  output  1  sticky: count wrapped during the current or last command.

## Operation
- States: IDLE, SETTLE, RUN, DONE. Registers: settle counter, remaining-step counter, q, up_down, wrap.
- IDLE: cmd_ready=1. Accept on an edge with cmd_valid=1. On accept, latch cmd_dir into up_down, load remaining=cmd_steps and clear wrap.
  - Next state is SETTLE if SETTLE>0, otherwise RUN.
  - If cmd_steps=0, next state is DONE directly with no counts and up_down still updated.
- SETTLE: cnt_en=0; up_down is stable; stay exactly SETTLE cycles, then go to RUN.
- RUN: cnt_en=1 every cycle. On each edge with cnt_en=1:
  - q <= q+1 if up_down=1, else q-1, modulo 16.
  - remaining decrements.
  - Leave to DONE on the edge that applies the last step.
- Wrap: set wrap on the edge where q goes 15->0 (up) or 0->15 (down). It stays set until the next accept.
- DONE: done=1, cnt_en=0, then return to IDLE.
- abort=1 in SETTLE or RUN: next state is DONE. No cnt_en is asserted after the sampling edge, and q keeps its value. The count applied on that same edge (if RUN) still takes effect. abort is ignored in IDLE and DONE.
- cmd_valid outside IDLE is ignored. The command is not queued; the requester holds it until cmd_ready.
- up_down changes only on accept. It never changes while cnt_en=1 or during SETTLE.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, q=0, up_down=1, cnt_en=0, done=0, wrap=0, busy=0, cmd_ready=1. Counters cleared.
- Reset mid-command aborts immediately with no done pulse. The first accept is possible on the first rising edge after rst deasserts.
- Let accept be edge E0 and N = cmd_steps > 0:
  - SETTLE cycles: edges E0 .. E0+SETTLE.
  - cnt_en high between edges E0+SETTLE and E0+SETTLE+N.
  - q is final and done=1 after edge E0+SETTLE+N.
  - cmd_ready=1 after edge E0+SETTLE+N+1.
- N=0: done=1 after E0+1, cmd_ready after E0+2.
- Throughput: one command per SETTLE+N+2 cycles. No back-to-back accept in the DONE cycle.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst=0 mid-RUN -> all outputs take reset values immediately, q=0, and no done follows. Release, then accept next cycle -> works normally.
- Up count, SETTLE=1: q=0, cmd_dir=1, cmd_steps=3, accept at E0 -> cnt_en high for edges E1..E4 window (3 cycles), q=1,2,3, done after E4, wrap=0, cmd_ready after E5.
- Down wrap: q=1, cmd_dir=0, cmd_steps=3 -> q=0,15,14, wrap=1 set on the 0->15 edge and held after done. Next accept clears wrap.
- Abort: q=5, up, cmd_steps=10, abort raised for 1 cycle after 4 counts -> q=9, no further cnt_en, done one cycle later, cmd_ready the cycle after.
- Zero steps and ignored input: cmd_steps=0 with cmd_dir=0 from up_down=1 -> up_down=0, no cnt_en, done 1 cycle after accept. cmd_valid held during busy -> no second accept until cmd_ready=1.
- Full range: q=0, up, cmd_steps=15 -> exactly 15 cnt_en cycles, q=15, wrap=0. A follow-up up 1 step gives q=0 and wrap=1.
